// File: rtl/nios_fast_oci_trace_im.sv
`default_nettype none
// ============================================================================
// nios_fast_oci_trace_im : circular instruction-trace RAM with JTAG readout.
// Optional macro NIOS_FAST_TRACE_TRIGGER_STOP_EN: stop POST_TRIG words after trc_trigger.
// Revision: 1.0
// ============================================================================
module nios_fast_oci_trace_im #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 36,
  parameter int POST_TRIG = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tw_valid,
  input  logic [DATA_W-1:0] tw_data,
  input  logic              trc_trigger,
  input  logic [37:0]       jdo,
  input  logic              take_action_tracectrl,
  input  logic              take_action_tracemem_a,
  input  logic              take_no_action_tracemem_a,
  input  logic              take_action_tracemem_b,
  output logic              trc_on,
  output logic              tracemem_on,
  output logic [ADDR_W-1:0] trc_im_addr,
  output logic              trc_wrap,
  output logic [DATA_W-1:0] tracemem_trcdata,
  output logic              tracemem_tw
);

  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  logic [DATA_W-1:0] mem [DEPTH];

  logic              trc_on_q, trc_on_d;
  logic              tracemem_on_q, tracemem_on_d;
  logic [ADDR_W-1:0] trc_im_addr_q, trc_im_addr_d;
  logic              trc_wrap_q, trc_wrap_d;
  logic              wrap_mode_q, wrap_mode_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] trcdata_q, trcdata_d;
  logic              tw_q, tw_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              capture;

  // A control write in the same cycle as a trace word drops the word.
  assign capture = tw_valid && tracemem_on_q && !take_action_tracectrl;

`ifdef NIOS_FAST_TRACE_TRIGGER_STOP_EN
  localparam int CNT_W = (POST_TRIG < 2) ? 1 : $clog2(POST_TRIG + 1);
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic unused_ok;
  assign unused_ok = ^{trc_trigger, jdo};

  always_comb begin
    trc_on_d      = trc_on_q;
    tracemem_on_d = tracemem_on_q;
    trc_im_addr_d = trc_im_addr_q;
    trc_wrap_d    = trc_wrap_q;
    wrap_mode_d   = wrap_mode_q;
    rd_addr_d     = rd_addr_q;
    rd_pend_d     = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = trc_im_addr_q;
    mem_wdata     = tw_data;
    trcdata_d     = rd_pend_q ? mem[rd_addr_q] : trcdata_q;
    tw_d          = rd_pend_q ? (trc_wrap_q || (rd_addr_q < trc_im_addr_q)) : tw_q;

    if (take_action_tracectrl) begin
      if (jdo[4]) begin
        trc_im_addr_d = '0;
        trc_wrap_d    = 1'b0;
      end
      trc_on_d      = jdo[3];
      tracemem_on_d = jdo[3];
      wrap_mode_d   = jdo[2];
    end else if (capture) begin
      mem_we        = 1'b1;
      trc_im_addr_d = trc_im_addr_q + 1'b1;
      if (trc_im_addr_q == LAST_ADDR) begin
        trc_wrap_d = 1'b1;
        if (!wrap_mode_q) tracemem_on_d = 1'b0;
      end
    end

    // JTAG write only while idle, so it never collides with a capture write.
    if (take_action_tracemem_b) begin
      if (!tracemem_on_q) begin
        mem_we    = 1'b1;
        mem_waddr = rd_addr_q;
        mem_wdata = jdo[DATA_W-1:0];
        rd_addr_d = rd_addr_q + 1'b1;
      end
    end else if (take_action_tracemem_a) begin
      rd_addr_d = jdo[ADDR_W+16:17];
      rd_pend_d = 1'b1;
    end else if (take_no_action_tracemem_a) begin
      rd_addr_d = rd_addr_q + 1'b1;
      rd_pend_d = 1'b1;
    end

`ifdef NIOS_FAST_TRACE_TRIGGER_STOP_EN
    armed_d = armed_q;
    cnt_d   = cnt_q;
    if (take_action_tracectrl) begin
      if (jdo[3]) armed_d = 1'b0;
    end else if (armed_q) begin
      if (capture) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          armed_d       = 1'b0;
          tracemem_on_d = 1'b0;
        end
      end
    end else if (trc_trigger && tracemem_on_q) begin
      armed_d = 1'b1;
      cnt_d   = CNT_W'(POST_TRIG);
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trc_on_q      <= 1'b0;
      tracemem_on_q <= 1'b0;
      trc_im_addr_q <= '0;
      trc_wrap_q    <= 1'b0;
      wrap_mode_q   <= 1'b0;
      rd_addr_q     <= '0;
      rd_pend_q     <= 1'b0;
      trcdata_q     <= '0;
      tw_q          <= 1'b0;
`ifdef NIOS_FAST_TRACE_TRIGGER_STOP_EN
      armed_q       <= 1'b0;
      cnt_q         <= '0;
`endif
    end else begin
      trc_on_q      <= trc_on_d;
      tracemem_on_q <= tracemem_on_d;
      trc_im_addr_q <= trc_im_addr_d;
      trc_wrap_q    <= trc_wrap_d;
      wrap_mode_q   <= wrap_mode_d;
      rd_addr_q     <= rd_addr_d;
      rd_pend_q     <= rd_pend_d;
      trcdata_q     <= trcdata_d;
      tw_q          <= tw_d;
`ifdef NIOS_FAST_TRACE_TRIGGER_STOP_EN
      armed_q       <= armed_d;
      cnt_q         <= cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign trc_on           = trc_on_q;
  assign tracemem_on      = tracemem_on_q;
  assign trc_im_addr      = trc_im_addr_q;
  assign trc_wrap         = trc_wrap_q;
  assign tracemem_trcdata = trcdata_q;
  assign tracemem_tw      = tw_q;

endmodule
`default_nettype wire

// File: tb/tb_nios_fast_oci_trace_im.sv
`default_nettype none
// Testbench for nios_fast_oci_trace_im: reference model + read scoreboard.
module tb_nios_fast_oci_trace_im;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 36;
  localparam int POST_TRIG = 16;
  localparam int DEPTH = 128;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              tw_valid = 1'b0;
  logic [DATA_W-1:0] tw_data = '0;
  logic              trc_trigger = 1'b0;
  logic [37:0]       jdo = '0;
  logic              take_action_tracectrl = 1'b0;
  logic              take_action_tracemem_a = 1'b0;
  logic              take_no_action_tracemem_a = 1'b0;
  logic              take_action_tracemem_b = 1'b0;
  logic              trc_on, tracemem_on, trc_wrap, tracemem_tw;
  logic [ADDR_W-1:0] trc_im_addr;
  logic [DATA_W-1:0] tracemem_trcdata;

  always #5 clk = ~clk;

  nios_fast_oci_trace_im #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .POST_TRIG(POST_TRIG)) dut (
    .clk(clk), .reset(reset), .tw_valid(tw_valid), .tw_data(tw_data),
    .trc_trigger(trc_trigger), .jdo(jdo),
    .take_action_tracectrl(take_action_tracectrl),
    .take_action_tracemem_a(take_action_tracemem_a),
    .take_no_action_tracemem_a(take_no_action_tracemem_a),
    .take_action_tracemem_b(take_action_tracemem_b),
    .trc_on(trc_on), .tracemem_on(tracemem_on), .trc_im_addr(trc_im_addr),
    .trc_wrap(trc_wrap), .tracemem_trcdata(tracemem_trcdata), .tracemem_tw(tracemem_tw)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit  m_val [DEPTH];
  int  m_addr, m_rd, m_cnt;
  bit  m_wrap, m_on, m_trc, m_wm, m_pend, m_armed;
  bit  mon_en = 1'b0;

  typedef struct {
    logic [DATA_W-1:0] data;
    bit tw;
    bit known;
  } exp_t;
  exp_t exp_q[$];

  task automatic model_reset();
    m_addr = 0; m_rd = 0; m_cnt = 0;
    m_wrap = 0; m_on = 0; m_trc = 0; m_wm = 0; m_pend = 0; m_armed = 0;
    exp_q.delete();
  endtask

  // One clock of the specified behaviour, evaluated on inputs held at the edge.
  task automatic model_step();
    bit on0 = m_on;
    bit armed0 = m_armed;
    exp_t e;
    if (m_pend) begin
      e.data  = m_mem[m_rd];
      e.known = m_val[m_rd];
      e.tw    = m_wrap || (m_rd < m_addr);
      exp_q.push_back(e);
    end
    m_pend = 0;
    if (take_action_tracectrl) begin
      if (jdo[4]) begin m_addr = 0; m_wrap = 0; end
      m_trc = jdo[3]; m_on = jdo[3]; m_wm = jdo[2];
      if (jdo[3]) m_armed = 0;
    end else begin
      if (tw_valid && on0) begin
        m_mem[m_addr] = tw_data;
        m_val[m_addr] = 1;
        if (m_addr == DEPTH - 1) begin
          m_wrap = 1;
          if (!m_wm) m_on = 0;
        end
        m_addr = (m_addr + 1) % DEPTH;
`ifdef NIOS_FAST_TRACE_TRIGGER_STOP_EN
        if (armed0) begin
          m_cnt = m_cnt - 1;
          if (m_cnt <= 0) begin m_on = 0; m_armed = 0; end
        end
`endif
      end
`ifdef NIOS_FAST_TRACE_TRIGGER_STOP_EN
      if (trc_trigger && on0 && !armed0) begin m_armed = 1; m_cnt = POST_TRIG; end
`endif
    end
    if (take_action_tracemem_b) begin
      if (!on0) begin
        m_mem[m_rd] = jdo[DATA_W-1:0];
        m_val[m_rd] = 1;
        m_rd = (m_rd + 1) % DEPTH;
      end
    end else if (take_action_tracemem_a) begin
      m_rd = int'(jdo[23:17]);
      m_pend = 1;
    end else if (take_no_action_tracemem_a) begin
      m_rd = (m_rd + 1) % DEPTH;
      m_pend = 1;
    end
  endtask

  always @(posedge clk) if (!reset) model_step();

  // Monitor: status every cycle, read data whenever a read result is due.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("trc_on", trc_on, m_trc);
      chk("tracemem_on", tracemem_on, m_on);
      chk("trc_im_addr", trc_im_addr, m_addr);
      chk("trc_wrap", trc_wrap, m_wrap);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rd_tw", tracemem_tw, e.tw);
        if (e.known) chk("rd_data", tracemem_trcdata, e.data);
      end
    end
  end

  task automatic idle_inputs();
    tw_valid = 0; trc_trigger = 0; take_action_tracectrl = 0;
    take_action_tracemem_a = 0; take_no_action_tracemem_a = 0; take_action_tracemem_b = 0;
  endtask
  task automatic step();
    @(posedge clk); #1; idle_inputs();
  endtask
  task automatic ctrl(input logic [2:0] b);
    jdo = '0; jdo[4:2] = b; take_action_tracectrl = 1; step();
  endtask
  task automatic word(input logic [DATA_W-1:0] d);
    tw_valid = 1; tw_data = d; step();
  endtask
  task automatic rd_a(input int a);
    logic [6:0] a7 = a[6:0];
    jdo = '0; jdo[23:17] = a7; take_action_tracemem_a = 1; step();
  endtask
  task automatic rd_n();
    take_no_action_tracemem_a = 1; step();
  endtask
  task automatic wr_b(input logic [DATA_W-1:0] d);
    jdo = '0; jdo[DATA_W-1:0] = d; take_action_tracemem_b = 1; step();
  endtask
  task automatic do_reset();
    reset = 1; model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  initial begin
    logic [DATA_W-1:0] pat;
    pat = 36'hA5A5A5A5A;
    model_reset();
    #1;
    do_reset();
    mon_en = 1;
    chk("reset_trcdata", tracemem_trcdata, 0);
    chk("reset_tw", tracemem_tw, 0);
    chk("reset_addr", trc_im_addr, 0);
    chk("reset_on", tracemem_on, 0);

    ctrl(3'b111);
    for (int i = 1; i <= 5; i++) word(DATA_W'(i));
    chk("five_addr", trc_im_addr, 5);
    chk("five_wrap", trc_wrap, 0);
    chk("five_on", tracemem_on, 1);

    rd_a(3); rd_n();
    chk("rd3_data", tracemem_trcdata, 4);
    chk("rd3_tw", tracemem_tw, 1);
    rd_n();
    chk("rd4_data", tracemem_trcdata, 5);
    chk("rd4_tw", tracemem_tw, 1);
    step();
    chk("rd5_tw", tracemem_tw, 0);

    ctrl(3'b110);
    for (int i = 0; i < 130; i++) word(DATA_W'(i + 1000));
    chk("stop_wrap", trc_wrap, 1);
    chk("stop_on", tracemem_on, 0);
    chk("stop_trc_on", trc_on, 1);
    chk("stop_addr", trc_im_addr, 0);

    ctrl(3'b111);
    for (int i = 0; i < 130; i++) word(DATA_W'(i));
    chk("circ_addr", trc_im_addr, 2);
    chk("circ_wrap", trc_wrap, 1);
    rd_a(0); step();
    chk("circ_rd0_data", tracemem_trcdata, 128);
    chk("circ_rd0_tw", tracemem_tw, 1);

    rd_a(10); wr_b(pat);
    rd_a(10); step();
    chk("jwr_ignored", tracemem_trcdata, 10);
    ctrl(3'b000);
    rd_a(10); wr_b(pat);
    rd_a(10); step();
    chk("jwr_data", tracemem_trcdata, pat);

    // Control and capture together; all three JTAG strobes together.
    ctrl(3'b111);
    jdo = '0; jdo[4:2] = 3'b111; take_action_tracectrl = 1; tw_valid = 1; tw_data = 36'h123; step();
    chk("ctrl_beats_capture", trc_im_addr, 0);
    jdo = '0; jdo[23:17] = 7'd20; take_action_tracemem_a = 1;
    take_no_action_tracemem_a = 1; take_action_tracemem_b = 1; step();
    step();

    for (int c = 0; c < 600; c++) begin
      take_action_tracectrl = ($urandom_range(0, 15) == 0);
      jdo = 38'({$urandom(), $urandom()});
      tw_valid = $urandom_range(0, 1) == 1;
      tw_data = 36'({$urandom(), $urandom()});
      trc_trigger = ($urandom_range(0, 19) == 0);
      take_action_tracemem_a = ($urandom_range(0, 5) == 0);
      take_no_action_tracemem_a = ($urandom_range(0, 5) == 0);
      take_action_tracemem_b = ($urandom_range(0, 5) == 0);
      step();
    end

    // Reset asserted in the middle of a capture burst.
    ctrl(3'b111);
    for (int i = 0; i < 3; i++) word(DATA_W'(i + 7));
    tw_valid = 1; tw_data = 36'h77;
    do_reset();
    idle_inputs();
    rd_a(0); step();
    chk("post_reset_tw", tracemem_tw, 0);

`ifdef NIOS_FAST_TRACE_TRIGGER_STOP_EN
    do_reset();
    ctrl(3'b111);
    for (int i = 0; i < 10; i++) word(DATA_W'(i));
    trc_trigger = 1; step();
    for (int i = 0; i < 25; i++) begin
      trc_trigger = (i % 4 == 0);
      word(DATA_W'(i + 100));
    end
    chk("trig_addr", trc_im_addr, 26);
    chk("trig_on", tracemem_on, 0);
`endif

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nios_fast_oci_trace_im.md
Name: nios_fast_oci_trace_im

Overview:
- On-chip instruction-trace memory feeding the JTAG debug module wrapper.
- Captures packed trace words from the trace packer into a circular RAM, under control bits written over JTAG.
- Exposes capture status (tracemem_on, trc_im_addr, trc_wrap, trc_on) and a JTAG readout path (tracemem_trcdata, tracemem_tw).
- Consumes the debug module's jdo / take_action_* strobes.

Parameters:
- ADDR_W, 7, trace RAM address width (depth = 2**ADDR_W).
- DATA_W, 36, trace word width.
- POST_TRIG, 16, words still captured after a trigger (optional feature only).

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- tw_valid  in  1  trace packer word strobe.
- tw_data  in  DATA_W  packed trace word.
- trc_trigger  in  1  trigger pulse from break/trigger logic (used only with optional feature).
- jdo  in  38  JTAG data-out register.
- take_action_tracectrl  in  1  load control bits from jdo.
- take_action_tracemem_a  in  1  load read address from jdo[ADDR_W+16:17] and read.
- take_no_action_tracemem_a  in  1  increment read address and read.
- take_action_tracemem_b  in  1  JTAG write jdo[DATA_W-1:0] at read address, then increment.
- trc_on  out  1  programmed trace enable.
- tracemem_on  out  1  capture currently active.
- trc_im_addr  out  ADDR_W  next capture write address.
- trc_wrap  out  1  capture pointer has wrapped at least once.
- tracemem_trcdata  out  DATA_W  RAM word at last read address.
- tracemem_tw  out  1  tracemem_trcdata is a valid captured entry.

Behaviour:
- Reset: all outputs 0; rd_addr=0; wrap_mode=0; trigger counter idle. RAM contents are not reset.
- Control (take_action_tracectrl):
  - jdo[4]=1: trc_im_addr<=0, trc_wrap<=0.
  - jdo[3] loads trc_on and tracemem_on.
  - jdo[2] loads wrap_mode (1=circular, 0=stop when full).
- Capture: when tw_valid && tracemem_on:
  - mem[trc_im_addr]<=tw_data; trc_im_addr<=trc_im_addr+1 (mod 2**ADDR_W).
  - On write at address all-ones: trc_wrap<=1. If wrap_mode=0, also tracemem_on<=0 after that write; trc_on is unchanged.
- Simultaneous events:
  - tracectrl and capture in the same cycle: control wins and the capture word is dropped.
  - Any of the three JTAG strobes asserted together: priority tracemem_b > tracemem_a > no_action_tracemem_a.
- Readout:
  - tracemem_a / no_action_a update rd_addr in cycle N.
  - tracemem_trcdata = mem[new rd_addr] in cycle N+1 (registered read, latency 1).
  - tracemem_trcdata holds until the next read.
  - rd_addr increment wraps modulo depth.
- tracemem_tw is registered with the data: 1 iff trc_wrap=1 or rd_addr < trc_im_addr at read time.
- JTAG write (tracemem_b):
  - Honoured only when tracemem_on=0; ignored while capturing.
  - Does not alter trc_im_addr or trc_wrap.
- RAM: one write port (capture or JTAG, mutually exclusive by the rule above) and one synchronous read port. Read-during-write to the same address returns the old data.
- Reset asserted mid-capture: capture stops immediately; pointers cleared; tracemem_tw=0 on the next read until new data is captured.

Optional Feature:
- Macro: NIOS_FAST_TRACE_TRIGGER_STOP_EN.
- Defined:
  - trc_trigger while tracemem_on arms a down-counter loaded with POST_TRIG.
  - Each captured word decrements it; on reaching 0, tracemem_on<=0.
  - Further triggers while armed are ignored.
  - tracectrl with jdo[3]=1 disarms the counter.
- Undefined: trc_trigger is ignored and no counter logic is built.

Test Plan:
- Reset, then tracectrl jdo[4:2]=3'b111, 5 tw_valid words 0x1..0x5 -> trc_im_addr=5, trc_wrap=0, tracemem_on=1.
- Stop mode (jdo[4:2]=3'b110), 130 words -> 128 written, trc_wrap=1, tracemem_on=0 after word 128, trc_im_addr=0.
- Circular mode, 130 words with value=index -> trc_wrap=1, trc_im_addr=2; read address 0 -> tracemem_trcdata=128, tracemem_tw=1 one cycle later.
- After 5 captures, tracemem_a with address 3 then two no_action_a -> data 4,5 with tw=1, then tw=0 at address 5.
- tracemem_b write 0xA5A5A5A5A while tracemem_on=1 -> ignored; same write with tracemem_on=0 reads back 0xA5A5A5A5A.
- (Macro on) trigger after 10 words, POST_TRIG=16 -> tracemem_on=0 with trc_im_addr=26; extra triggers while armed have no effect.
